// File: rtl/alu_pkg.sv
// alu_pkg: ALUSELECT codes shared with the ALU control decoder and the sequential ALU FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    typedef enum logic [1:0] {
        REPOSO,
        DESPLAZA,
        FIN
    } estado_t;

endpackage

// File: rtl/alu_desplazador.sv
// alu_desplazador: iterative one-bit-per-cycle shifter with down-counter and latched direction.
module alu_desplazador #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               dir,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               last
);

    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               activo;

    // data_out is the value after the step in progress, so the final shift can be captured directly
    assign data_out = dir_q ? (sreg_q >> 1) : (sreg_q << 1);
    assign last     = cnt_q == SHAMT_W'(1);
    assign activo   = cnt_q != '0;

    always_comb begin
        sreg_d = load ? data_in  : (activo ? data_out : sreg_q);
        cnt_d  = load ? shamt_in : (activo ? cnt_q - SHAMT_W'(1) : cnt_q);
        dir_d  = load ? dir      : dir_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end

endmodule

// File: rtl/alu_secuencial.sv
// alu_secuencial: multicycle-datapath ALU with START/BUSY/DONE handshake; shifts run one bit per cycle.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       ALUSELECT,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULTADO,
    output logic             ZERO,
    output logic             ILEGAL
);

    localparam int SHAMT_W = $clog2(WIDTH);

    estado_t            estado_q, estado_d;
    logic [WIDTH-1:0]   resultado_q, resultado_d;
    logic               ilegal_q, ilegal_d;
    logic [WIDTH-1:0]   res_simple;
    logic [WIDTH-1:0]   desp_out;
    logic               desp_ultimo;
    logic [SHAMT_W-1:0] shamt;
    logic               es_shift;
    logic               carga;

    assign shamt    = OPB[SHAMT_W-1:0];
    assign es_shift = (ALUSELECT == ALU_SLL) || (ALUSELECT == ALU_SRL);
    assign carga    = (estado_q == REPOSO) && START && es_shift && (shamt != '0);

    alu_desplazador #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_desplazador (
        .clk      (CLK),
        .rst      (RST),
        .load     (carga),
        .dir      (ALUSELECT == ALU_SRL),
        .data_in  (OPA),
        .shamt_in (shamt),
        .data_out (desp_out),
        .last     (desp_ultimo)
    );

    // Shifts reach here only with shamt 0, where the result is OPA unchanged
    always_comb begin
        case (ALUSELECT)
            ALU_ADD: res_simple = OPA + OPB;
            ALU_SUB: res_simple = OPA - OPB;
            ALU_AND: res_simple = OPA & OPB;
            ALU_OR:  res_simple = OPA | OPB;
            ALU_XOR: res_simple = OPA ^ OPB;
            ALU_SLT: res_simple = {{(WIDTH-1){1'b0}}, $signed(OPA) < $signed(OPB)};
            ALU_SLL, ALU_SRL: res_simple = OPA;
            default: res_simple = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado_q    <= REPOSO;
            resultado_q <= '0;
            ilegal_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            resultado_q <= resultado_d;
            ilegal_q    <= ilegal_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        resultado_d = resultado_q;
        ilegal_d    = ilegal_q;
        case (estado_q)
            REPOSO: begin
                if (START) begin
                    if (ALUSELECT[3]) begin
                        estado_d    = FIN;
                        resultado_d = '0;
                        ilegal_d    = 1'b1;
                    end else if (carga) begin
                        estado_d = DESPLAZA;
                    end else begin
                        estado_d    = FIN;
                        resultado_d = res_simple;
                        ilegal_d    = 1'b0;
                    end
                end
            end
            DESPLAZA: begin
                if (desp_ultimo) begin
                    estado_d    = FIN;
                    resultado_d = desp_out;
                    ilegal_d    = 1'b0;
                end
            end
            FIN:     estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    always_comb begin
        BUSY      = estado_q != REPOSO;
        DONE      = estado_q == FIN;
        RESULTADO = resultado_q;
        ZERO      = resultado_q == '0;
        ILEGAL    = ilegal_q;
    end

endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed self-checking bench for alu_secuencial (handshake, ops, shift latency, abort, reserved codes).
module tb_alu_secuencial;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [3:0]  ALUSELECT;
    logic [31:0] OPA, OPB;
    logic        BUSY, DONE, ZERO, ILEGAL;
    logic [31:0] RESULTADO;

    int errors = 0;
    int checks = 0;
    int lat;
    int ndone;
    logic [31:0] r_res;
    logic        r_zero, r_il;

    alu_secuencial #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .ALUSELECT (ALUSELECT),
        .OPA       (OPA),
        .OPB       (OPB),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULTADO (RESULTADO),
        .ZERO      (ZERO),
        .ILEGAL    (ILEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge in REPOSO; returns at the negedge of cycle t+1 with inputs scrambled
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        START = 1'b1;
        ALUSELECT = sel;
        OPA = a;
        OPB = b;
        @(negedge CLK);
        START = 1'b0;
        ALUSELECT = 4'hF;
        OPA = 32'hDEAD_BEEF;
        OPB = 32'h1234_5677;
    endtask

    // Latency is counted so that the current negedge is cycle t+first
    task automatic wait_done(input int first, output int l);
        l = -1;
        for (int i = first; i < first + 100; i++) begin
            if (DONE) begin
                l = i;
                r_res = RESULTADO;
                r_zero = ZERO;
                r_il = ILEGAL;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic run(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        issue(sel, a, b);
        wait_done(1, lat);
        @(negedge CLK);
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (DONE) c++;
            @(negedge CLK);
        end
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        ALUSELECT = '0;
        OPA = '0;
        OPB = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_res", RESULTADO, 32'd0);
        chk("rst_zero", 32'(ZERO), 32'd1);
        chk("rst_ilegal", 32'(ILEGAL), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        issue(ALU_ADD, 32'd7, 32'd5);
        chk("add_done_t1", 32'(DONE), 32'd1);
        chk("add_busy_t1", 32'(BUSY), 32'd1);
        chk("add_res", RESULTADO, 32'd12);
        chk("add_zero", 32'(ZERO), 32'd0);
        @(negedge CLK);
        chk("add_done_t2", 32'(DONE), 32'd0);
        chk("add_busy_t2", 32'(BUSY), 32'd0);
        chk("add_res_hold", RESULTADO, 32'd12);

        run(ALU_SUB, 32'd5, 32'd5);
        chk("sub_lat", 32'(lat), 32'd1);
        chk("sub_res", r_res, 32'd0);
        chk("sub_zero", 32'(r_zero), 32'd1);
        run(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        chk("addwrap_res", r_res, 32'd0);
        chk("addwrap_zero", 32'(r_zero), 32'd1);
        run(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg", r_res, 32'd1);
        run(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        chk("slt_pos", r_res, 32'd0);
        run(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        chk("and_res", r_res, 32'h0F00_0F00);
        run(ALU_OR, 32'hF000_000F, 32'h0000_F0F0);
        chk("or_res", r_res, 32'hF000_F0FF);
        run(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
        chk("xor_res", r_res, 32'h0F0F_F0F0);

        issue(ALU_SLL, 32'd1, 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("sll4_busy_t%0d", k), 32'(BUSY), 32'd1);
            chk($sformatf("sll4_done_t%0d", k), 32'(DONE), 32'd0);
            chk($sformatf("sll4_hold_t%0d", k), RESULTADO, 32'h0F0F_F0F0);
            @(negedge CLK);
        end
        chk("sll4_done_t5", 32'(DONE), 32'd1);
        chk("sll4_busy_t5", 32'(BUSY), 32'd1);
        chk("sll4_res", RESULTADO, 32'h10);
        @(negedge CLK);
        chk("sll4_busy_t6", 32'(BUSY), 32'd0);

        run(ALU_SRL, 32'h8000_0000, 32'd31);
        chk("srl31_lat", 32'(lat), 32'd32);
        chk("srl31_res", r_res, 32'd1);
        run(ALU_SLL, 32'hA5A5_0001, 32'h20);
        chk("sll0_lat", 32'(lat), 32'd1);
        chk("sll0_res", r_res, 32'hA5A5_0001);

        issue(ALU_SLL, 32'd3, 32'd8);
        @(negedge CLK);
        START = 1'b1;
        ALUSELECT = ALU_ADD;
        OPA = 32'd1;
        OPB = 32'd1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(3, lat);
        chk("ign_lat", 32'(lat), 32'd9);
        chk("ign_res", r_res, 32'h300);
        @(negedge CLK);
        count_dones(12, ndone);
        chk("ign_no_extra_done", 32'(ndone), 32'd0);

        issue(ALU_SLL, 32'd1, 32'd10);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_res", RESULTADO, 32'd0);
        chk("abort_zero", 32'(ZERO), 32'd1);
        chk("abort_done", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        count_dones(15, ndone);
        chk("abort_no_done", 32'(ndone), 32'd0);

        run(ALU_OR, 32'hA, 32'h5);
        chk("pre_il_res", r_res, 32'hF);
        run(4'b1001, 32'd9, 32'd9);
        chk("il_lat", 32'(lat), 32'd1);
        chk("il_res", r_res, 32'd0);
        chk("il_flag", 32'(r_il), 32'd1);
        chk("il_hold", 32'(ILEGAL), 32'd1);
        run(ALU_AND, 32'hFF, 32'h0F);
        chk("and_clr_il", 32'(r_il), 32'd0);
        chk("and_clr_res", r_res, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Execution-side consumer of the 4-bit ALUSELECT code generated by the ALU control decoder.
- Performs ADD, AND, OR, SLL, SLT, SRL, SUB and XOR on two WIDTH-bit operands under a START/BUSY/DONE handshake.
- Shifts run iteratively, one bit per cycle; all other ops finish in one cycle.
- Sits in the execute stage of the multicycle RISC-V datapath, between the register-file/immediate mux and the result write-back register.

Parameters:
- WIDTH, 32, operand/result width in bits. Derived localparam SHAMT_W = $clog2(WIDTH).

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in state REPOSO.
- ALUSELECT  in  4  operation code, sampled with START.
- OPA  in  WIDTH  operand A, sampled with START.
- OPB  in  WIDTH  operand B (shift amount = OPB[SHAMT_W-1:0]), sampled with START.
- BUSY  out  1  high whenever state != REPOSO.
- DONE  out  1  one-cycle pulse; RESULTADO/ZERO/ILEGAL valid.
- RESULTADO  out  WIDTH  registered result; holds until the next completion.
- ZERO  out  1  (RESULTADO == 0).
- ILEGAL  out  1  registered; set on completion of a reserved code.

Behaviour:
- Reset (async, immediate): state REPOSO, BUSY=0, DONE=0, RESULTADO=0, ZERO=1, ILEGAL=0. Shift register and counter are cleared.
- Codes: 0000 ADD, 0001 AND, 0010 OR, 0011 SLL, 0100 SLT, 0101 SRL, 0110 SUB, 0111 XOR. Codes 1000-1111 are reserved.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- SLT: 1 if $signed(OPA) < $signed(OPB), else 0; zero-extended to WIDTH.
- SRL is logical (zero fill). SLL zero-fills.
- FSM states: REPOSO, DESPLAZA, FIN.
- REPOSO, with START=1 at cycle t:
  - Non-shift op: result is computed and loaded into the result register at the end of t. Next state FIN, so DONE=1 at t+1.
  - Shift with shamt N=0: RESULTADO=OPA, next state FIN, DONE at t+1.
  - Shift with N>0: shift register is loaded with OPA and the counter with N. Next state DESPLAZA.
  - Reserved code: RESULTADO=0, ILEGAL=1, next state FIN, DONE at t+1.
- DESPLAZA: each cycle shifts one bit in the selected direction and decrements the counter.
  - When the counter is 1, the final shift is copied into RESULTADO and next state is FIN.
  - DESPLAZA occupies cycles t+1..t+N; DONE at t+N+1.
- FIN: DONE=1 for exactly one cycle, then REPOSO unconditionally.
- Throughput: the earliest next accepted START is at t+2 (non-shift) or t+N+2 (shift).
- START while BUSY=1 (DESPLAZA or FIN) is ignored and not queued.
- RESULTADO, ZERO and ILEGAL change only on the edge entering FIN. They are stable during DESPLAZA and in REPOSO.
- ILEGAL is cleared on completion of any legal op.
- RST asserted mid-operation aborts it: no DONE is produced and all outputs take their reset values.
- ALUSELECT/OPA/OPB may change freely after the START cycle; all values are latched.

Decomposition:
- Package alu_pkg holds:
  - localparams for the eight ALUSELECT codes (shared with the ALU control decoder);
  - the FSM state enum (REPOSO, DESPLAZA, FIN).
- One natural sub-module, alu_desplazador:
  - contains the shift register, down-counter and direction bit;
  - interface: load, dir, data in, shamt in, data out, last-step flag.
- Single-cycle ops and the FSM stay in alu_secuencial.

Test Plan:
- Reset, then ADD OPA=7, OPB=5, START at t -> DONE=1 only at t+1, RESULTADO=12, ZERO=0, BUSY=1 at t+1 only.
- SUB 5-5 -> RESULTADO=0, ZERO=1. ADD 0xFFFFFFFF+1 -> RESULTADO=0, ZERO=1 (wrap).
- SLT 0xFFFFFFFF vs 1 -> 1. SLT 1 vs 0xFFFFFFFF -> 0. XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0.
- Shift latency:
  - SLL OPA=1, OPB=4 -> BUSY t+1..t+5, DONE at t+5, RESULTADO=0x10; RESULTADO unchanged during DESPLAZA.
  - SRL OPA=0x80000000, OPB=31 -> DONE at t+32, RESULTADO=1.
  - SLL OPB=0x20 (shamt 0) -> DONE at t+1, RESULTADO=OPA.
- START pulsed (ADD 1+1) at t+2 of an SLL with shamt 8 -> ignored; a single DONE at t+9 with the shift result.
- Reset and reserved code:
  - RST raised at t+3 of an SLL with shamt 10 -> BUSY=0, RESULTADO=0, ZERO=1 immediately; no DONE afterwards.
  - ALUSELECT=1001 -> DONE at t+1, RESULTADO=0, ILEGAL=1; a following AND clears ILEGAL.
